// File: rtl/kernel_pass_sequencer_if.sv
// Window/write-back handshake bundle between the pass sequencer and the filter datapath.
// The master modport is the sequencer side; the slave modport is the datapath side.
interface kernel_pass_sequencer_if #(
  parameter int ADDR_W = 9
);
  logic              mode;
  logic              start;
  logic              busy;
  logic [2:0]        op;
  logic [1:0]        win_size;
  logic [4:0]        win_row;
  logic [4:0]        win_col;
  logic [ADDR_W-1:0] win_addr;
  logic              win_valid;
  logic              win_ready;
  logic              wb_req;
  logic              wb_ack;
  logic              done;

  modport master (
    input  mode, start, win_ready, wb_ack,
    output busy, op, win_size, win_row, win_col, win_addr, win_valid, wb_req, done
  );

  modport slave (
    output mode, start, win_ready, wb_ack,
    input  busy, op, win_size, win_row, win_col, win_addr, win_valid, wb_req, done
  );
endinterface

// File: rtl/kernel_pass_sequencer.sv
// Steps the image filter through its ordered passes, issuing column-major window positions per pass.
// Latency: start->first window 1 cycle, 1 position/cycle; backpressure: window held until win_ready, wb_req held until wb_ack.
module kernel_pass_sequencer #(
  parameter int IMG_DIM = 20,
  parameter int ADDR_W  = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  kernel_pass_sequencer_if.master bus
);

  localparam int POS_W = 5;
  localparam logic [POS_W-1:0] MAX_POS = POS_W'(IMG_DIM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_WB   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_IDLE  = 3'd0,
    OP_MED   = 3'd1,
    OP_GAU   = 3'd2,
    OP_SOBEL = 3'd3,
    OP_NMAX  = 3'd4,
    OP_HYST  = 3'd5,
    OP_QUANT = 3'd6
  } op_e;

  typedef struct packed {
    logic [POS_W-1:0] row;
    logic [POS_W-1:0] col;
  } pos_t;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [2:0]        pass_q, pass_d;
  op_e               op_q, op_d;
  logic [1:0]        size_q, size_d;
  pos_t              pos_q, pos_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              wb_req_q, wb_req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [POS_W-1:0]  lim;

  // Pass order per mode: 0 = EDGE, 1 = COLOR.
  function automatic op_e pass_op(input logic m, input logic [2:0] idx);
    op_e r;
    r = OP_IDLE;
    if (!m) begin
      case (idx)
        3'd0:    r = OP_MED;
        3'd1:    r = OP_GAU;
        3'd2:    r = OP_SOBEL;
        3'd3:    r = OP_NMAX;
        3'd4:    r = OP_HYST;
        default: r = OP_IDLE;
      endcase
    end else begin
      case (idx)
        3'd0:    r = OP_GAU;
        3'd1:    r = OP_MED;
        3'd2:    r = OP_QUANT;
        default: r = OP_IDLE;
      endcase
    end
    return r;
  endfunction

  function automatic logic [1:0] op_size(input op_e o);
    logic [1:0] s;
    case (o)
      OP_GAU:             s = 2'd2;
      OP_QUANT, OP_IDLE:  s = 2'd0;
      default:            s = 2'd1;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] last_pass(input logic m);
    return m ? 3'd2 : 3'd4;
  endfunction

  // Last legal top-left coordinate is IMG_DIM-K, with K = 2*win_size+1.
  assign lim = MAX_POS - POS_W'({size_q, 1'b0});

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pass_d   = pass_q;
    op_d     = op_q;
    size_d   = size_q;
    pos_d    = pos_q;
    valid_d  = valid_q;
    wb_req_d = wb_req_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SCAN;
          mode_d  = bus.mode;
          pass_d  = 3'd0;
          op_d    = pass_op(bus.mode, 3'd0);
          size_d  = op_size(op_d);
          pos_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      S_SCAN: begin
        if (valid_q && bus.win_ready) begin
          if (pos_q.row < lim) begin
            pos_d.row = pos_q.row + 5'd1;
          end else if (pos_q.col < lim) begin
            pos_d.row = '0;
            pos_d.col = pos_q.col + 5'd1;
          end else begin
            state_d  = S_WB;
            valid_d  = 1'b0;
            wb_req_d = 1'b1;
          end
        end
      end

      S_WB: begin
        if (bus.wb_ack) begin
          wb_req_d = 1'b0;
          pos_d    = '0;
          if (pass_q == last_pass(mode_q)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            op_d    = OP_IDLE;
            size_d  = 2'd0;
          end else begin
            state_d = S_SCAN;
            pass_d  = pass_q + 3'd1;
            op_d    = pass_op(mode_q, pass_d);
            size_d  = op_size(op_d);
            valid_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Address follows the next position so the registered value never lags row/col.
    addr_d = ADDR_W'(pos_d.row) * ADDR_W'(IMG_DIM) + ADDR_W'(pos_d.col);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      pass_q   <= 3'd0;
      op_q     <= OP_IDLE;
      size_q   <= 2'd0;
      pos_q    <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      wb_req_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      pass_q   <= pass_d;
      op_q     <= op_d;
      size_q   <= size_d;
      pos_q    <= pos_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      wb_req_q <= wb_req_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.op        = op_q;
  assign bus.win_size  = size_q;
  assign bus.win_row   = pos_q.row;
  assign bus.win_col   = pos_q.col;
  assign bus.win_addr  = addr_q;
  assign bus.win_valid = valid_q;
  assign bus.wb_req    = wb_req_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_kernel_pass_sequencer.sv
// Bench for kernel_pass_sequencer: table of full-run scenarios checked against a position scoreboard,
// plus reset-mid-pass and done/start back-to-back sequences.
module tb_kernel_pass_sequencer;
  localparam int IMG_DIM = 20;
  localparam int ADDR_W  = 9;

  logic clk = 1'b0;
  logic reset;

  kernel_pass_sequencer_if #(.ADDR_W(ADDR_W)) bus();

  kernel_pass_sequencer #(.IMG_DIM(IMG_DIM), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] size;
    logic [4:0] row;
    logic [4:0] col;
    logic [8:0] addr;
  } exp_t;

  typedef struct packed {
    bit              mode;
    int              rdy_pct;
    int              ack_dly;
    bit              noise;
    int              npass;
    logic [4:0][2:0] ops;
    logic [4:0][9:0] cnt;
    int              total;
    int              chk_pass;
    int              last_row;
    int              last_col;
    int              last_addr;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference scan order straight from the pass list: col outer, row inner.
  task automatic push_model(input bit m);
    logic [2:0] ops[5];
    int np, k;
    exp_t e;
    if (!m) begin
      ops[0] = 3'd1; ops[1] = 3'd2; ops[2] = 3'd3; ops[3] = 3'd4; ops[4] = 3'd5; np = 5;
    end else begin
      ops[0] = 3'd2; ops[1] = 3'd1; ops[2] = 3'd6; ops[3] = 3'd0; ops[4] = 3'd0; np = 3;
    end
    for (int p = 0; p < np; p++) begin
      k = (ops[p] == 3'd2) ? 5 : (ops[p] == 3'd6) ? 1 : 3;
      for (int c = 0; c <= IMG_DIM - k; c++) begin
        for (int r = 0; r <= IMG_DIM - k; r++) begin
          e.op   = ops[p];
          e.size = 2'((k - 1) / 2);
          e.row  = 5'(r);
          e.col  = 5'(c);
          e.addr = 9'(r * IMG_DIM + c);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic run_seq(input vec_t v, input bit chain, input string tag);
    int acc[6], last_r[6], last_c[6], last_a[6];
    int pass_i, pos_err, hold_err, wb_err, misc_err, wb_pulses, done_cnt, valid_cyc, wb_cyc, cyc, total;
    bit fin, held, ack_prev, wb_prev, rdy, ack;
    exp_t e, hp, cur;
    logic [2:0] wb_op;
    logic [2:0] op_log[$];

    for (int i = 0; i < 6; i++) begin acc[i] = 0; last_r[i] = -1; last_c[i] = -1; last_a[i] = -1; end
    pass_i = 0; pos_err = 0; hold_err = 0; wb_err = 0; misc_err = 0; wb_pulses = 0;
    done_cnt = 0; valid_cyc = 0; wb_cyc = 0; cyc = 0;
    fin = 0; held = 0; ack_prev = 0; wb_prev = 0; wb_op = 3'd0; hp = '0;
    exp_q.delete();
    push_model(v.mode);

    @(negedge clk);
    bus.mode = v.mode; bus.start = 1'b1; bus.win_ready = 1'b0; bus.wb_ack = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_start_valid"}, int'(bus.win_valid), 1);
    chk({tag, "_start_busy"}, int'(bus.busy), 1);
    chk({tag, "_start_op"}, int'(bus.op), int'(v.ops[0]));
    chk({tag, "_start_size"}, int'(bus.win_size), v.mode ? 2 : 1);
    chk({tag, "_start_pos"}, int'(bus.win_row) + int'(bus.win_col) + int'(bus.win_addr), 0);

    while (!fin && cyc < 30000) begin
      cur.op = bus.op; cur.size = bus.win_size; cur.row = bus.win_row;
      cur.col = bus.win_col; cur.addr = bus.win_addr;
      bus.start = (v.noise && bus.busy) ? 1'($urandom_range(1)) : 1'b0;
      if (v.noise) bus.mode = 1'($urandom_range(1));

      if (bus.done) begin
        done_cnt++;
        if (bus.busy || bus.op != 3'd0 || bus.win_valid || bus.wb_req) misc_err++;
        fin = 1;
        if (chain) begin bus.start = 1'b1; bus.mode = 1'b0; end
      end else begin
        if (!bus.busy) misc_err++;
        if (ack_prev && !bus.win_valid) misc_err++;
      end
      ack_prev = 0;

      if (held && (!bus.win_valid || cur != hp)) hold_err++;
      held = 0;

      if (bus.win_valid) begin
        valid_cyc++;
        if (bus.wb_req) wb_err++;
        rdy = ($urandom_range(99) < v.rdy_pct);
        bus.win_ready = rdy;
        if (rdy) begin
          if (exp_q.size() == 0) pos_err++;
          else begin
            e = exp_q.pop_front();
            if (cur != e) pos_err++;
          end
          acc[pass_i]++;
          last_r[pass_i] = int'(cur.row); last_c[pass_i] = int'(cur.col); last_a[pass_i] = int'(cur.addr);
        end else begin
          held = 1;
          hp = cur;
        end
      end else begin
        bus.win_ready = 1'($urandom_range(1));
      end

      if (bus.wb_req) begin
        if (!wb_prev) begin
          wb_pulses++; op_log.push_back(bus.op); wb_cyc = 0; wb_op = bus.op;
        end
        if (bus.op != wb_op || bus.win_valid) wb_err++;
        ack = (wb_cyc >= v.ack_dly);
        bus.wb_ack = ack;
        ack_prev = ack;
        wb_cyc++;
        if (ack && pass_i < 5) pass_i++;
      end else begin
        bus.wb_ack = v.noise ? 1'($urandom_range(1)) : 1'b0;
      end
      wb_prev = bus.wb_req;
      cyc++;
      if (!fin) @(negedge clk);
    end

    if (!fin) chk({tag, "_timeout_done_seen"}, 0, 1);
    chk({tag, "_pos_mismatches"}, pos_err, 0);
    chk({tag, "_pos_left_over"}, exp_q.size(), 0);
    chk({tag, "_hold_violations"}, hold_err, 0);
    chk({tag, "_wb_violations"}, wb_err, 0);
    chk({tag, "_busy_done_violations"}, misc_err, 0);
    chk({tag, "_wb_pulses"}, wb_pulses, v.npass);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    total = 0;
    for (int i = 0; i < v.npass; i++) begin
      chk($sformatf("%s_op_seq_%0d", tag, i), (i < op_log.size()) ? int'(op_log[i]) : -1, int'(v.ops[i]));
      chk($sformatf("%s_pass_cnt_%0d", tag, i), acc[i], int'(v.cnt[i]));
      total += acc[i];
    end
    chk({tag, "_total"}, total, v.total);
    chk({tag, "_last_row"}, last_r[v.chk_pass], v.last_row);
    chk({tag, "_last_col"}, last_c[v.chk_pass], v.last_col);
    chk({tag, "_last_addr"}, last_a[v.chk_pass], v.last_addr);
    if (v.rdy_pct == 100) chk({tag, "_one_per_cycle"}, valid_cyc, v.total);

    bus.win_ready = 1'b0; bus.wb_ack = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_done_one_cycle"}, int'(bus.done), 0);
    if (chain) begin
      chk({tag, "_restart_busy"}, int'(bus.busy), 1);
      chk({tag, "_restart_valid"}, int'(bus.win_valid), 1);
      chk({tag, "_restart_op"}, int'(bus.op), 1);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_valid"}, int'(bus.win_valid), 0);
    chk({tag, "_wb_req"}, int'(bus.wb_req), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_op"}, int'(bus.op), 0);
    chk({tag, "_size"}, int'(bus.win_size), 0);
    chk({tag, "_row"}, int'(bus.win_row), 0);
    chk({tag, "_col"}, int'(bus.win_col), 0);
    chk({tag, "_addr"}, int'(bus.win_addr), 0);
  endtask

  initial begin
    bit found;

    vecs[0] = '{mode: 1'b0, rdy_pct: 100, ack_dly: 0, noise: 1'b0, npass: 5,
                ops: {3'd5, 3'd4, 3'd3, 3'd2, 3'd1},
                cnt: {10'd324, 10'd324, 10'd324, 10'd256, 10'd324},
                total: 1552, chk_pass: 1, last_row: 15, last_col: 15, last_addr: 315};
    vecs[1] = '{mode: 1'b1, rdy_pct: 100, ack_dly: 0, noise: 1'b0, npass: 3,
                ops: {3'd0, 3'd0, 3'd6, 3'd1, 3'd2},
                cnt: {10'd0, 10'd0, 10'd400, 10'd324, 10'd256},
                total: 980, chk_pass: 2, last_row: 19, last_col: 19, last_addr: 399};
    vecs[2] = vecs[0];
    vecs[2].rdy_pct = 50; vecs[2].ack_dly = 3; vecs[2].noise = 1'b1;
    vecs[3] = vecs[1];
    vecs[3].rdy_pct = 50; vecs[3].ack_dly = 10; vecs[3].noise = 1'b1;

    reset = 1'b0;
    bus.mode = 1'b0; bus.start = 1'b0; bus.win_ready = 1'b0; bus.wb_ack = 1'b0;
    @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_valid", int'(bus.win_valid), 0);

    for (int i = 0; i < 4; i++) run_seq(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // done and a new start in the same cycle: sequence restarts on the next edge.
    run_seq(vecs[1], 1'b1, "chain");
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset in the middle of the GAU pass at (7,3).
    bus.mode = 1'b1; bus.start = 1'b1; bus.win_ready = 1'b0; bus.wb_ack = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (bus.win_valid && bus.op == 3'd2 && bus.win_row == 5'd7 && bus.win_col == 5'd3) begin
        found = 1;
        bus.win_ready = 1'b0;
      end else begin
        bus.win_ready = 1'b1;
        @(negedge clk);
      end
    end
    chk("reach_gau_7_3", int'(found), 1);
    chk("mid_addr_7_3", int'(bus.win_addr), 143);
    reset = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", int'(bus.busy), 0);
    chk("post_rst_valid", int'(bus.win_valid), 0);
    chk("post_rst_op", int'(bus.op), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/kernel_pass_sequencer.md
# kernel_pass_sequencer

Sequencer for the 20x20 image filter datapath. After an image has been loaded into the image register file, it steps the chip through its ordered filter passes: median, gaussian, sobel, non-max and hysteresis for edge mode; gaussian, median and quantize for color mode. For each pass it walks the kernel window over every valid position and hands one position per handshake to the filter datapath. It also requests a write-back between passes and signals completion.

## Interface
Parameters:
- IMG_DIM, 20, image side length in pixels
- ADDR_W, 9, width of linear pixel address (must hold IMG_DIM*IMG_DIM-1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- mode  in  1  0 = EDGE, 1 = COLOR; sampled only on accepted start
- start  in  1  one-cycle pulse: image load complete, begin pass sequence
- busy  out  1  high from the cycle after an accepted start until done
- op  out  3  current pass: 0 IDLE, 1 MED_FIL, 2 GAU_FIL, 3 SOBEL, 4 NON_MAX, 5 HYSTER, 6 QUANTIZE
- win_size  out  2  kernel of current pass: 0 = 1x1, 1 = 3x3, 2 = 5x5
- win_row  out  5  top-left row of current window
- win_col  out  5  top-left column of current window
- win_addr  out  ADDR_W  win_row*IMG_DIM + win_col
- win_valid  out  1  window position presented to datapath
- win_ready  in  1  datapath accepts position this cycle
- wb_req  out  1  pass finished; datapath must copy temp results to image file
- wb_ack  in  1  write-back complete
- done  out  1  one-cycle pulse, whole sequence complete

## Operation
- States:
  - IDLE: no pass is active.
  - SCAN: window positions are issued to the datapath.
  - WB: waits for the write-back to finish.
- IDLE → SCAN on start. On the same edge:
  - latch mode;
  - load the first pass of the latched mode;
  - set row = col = 0.
- start is ignored while busy.
- Pass order:
  - EDGE: MED_FIL(3x3), GAU_FIL(5x5), SOBEL(3x3), NON_MAX(3x3), HYSTER(3x3).
  - COLOR: GAU_FIL(5x5), MED_FIL(3x3), QUANTIZE(1x1).
- Window scan for kernel size K:
  - Column-major order: row is the inner index, 0..IMG_DIM-K; col is the outer index, 0..IMG_DIM-K.
  - Positions per pass: 1x1 = 400, 3x3 = 324, 5x5 = 256.
- SCAN, on each win_valid && win_ready:
  - If row < IMG_DIM-K: row increments.
  - Otherwise, if col < IMG_DIM-K: row = 0 and col increments.
  - Otherwise this was the last position: go to WB, drop win_valid, assert wb_req.
- WB, on wb_ack:
  - If another pass remains: op advances, row = col = 0, return to SCAN.
  - If this was the last pass: pulse done, drop busy, set op = IDLE, return to IDLE.
- win_addr is registered and always consistent with win_row and win_col.
- Ignored inputs:
  - win_ready outside SCAN.
  - wb_ack outside WB.
  - mode changes while busy.
- Reset asserted at any time, including mid-pass: all state returns to reset values immediately. The datapath must treat the partial pass as discarded.

## Timing
- Reset values:
  - busy, win_valid, wb_req, done = 0
  - op = 0 (IDLE), win_size = 0
  - win_row, win_col, win_addr = 0
- All outputs are registered; no combinational path exists from any input to any output.
- Start latency: start sampled at edge t → in cycle t+1, win_valid = 1, busy = 1, and op/win_size show the first pass at (0,0).
- Throughput: one position per cycle when win_ready is held high.
- win_valid, win_row, win_col and win_addr stay stable until accepted (valid/ready rule).
- Last-position handshake at edge t → in cycle t+1, wb_req = 1 and win_valid = 0. wb_req is held until wb_ack.
- wb_ack at edge t → in cycle t+1, either win_valid = 1 at (0,0) of the next pass, or done = 1 and busy = 0.
- wb_ack arriving in the same cycle that wb_req first rises is legal and is accepted.
- done lasts exactly one cycle. A start in that same cycle is accepted and begins a new sequence on the next edge.

## Test plan
- Reset and idle: drive reset low mid-SCAN of GAU_FIL at (7,3) → all outputs return to reset values. After release, the block stays in IDLE until start.
- EDGE full run with win_ready = 1 and wb_ack = 1:
  - op sequence is 1, 2, 3, 4, 5;
  - accepted positions per pass: 324, 256, 324, 324, 324 (1552 total);
  - exactly 5 wb_req pulses, then one done;
  - last GAU position is row = 15, col = 15, addr = 315.
- COLOR full run:
  - op sequence is 2, 1, 6;
  - accepted positions: 256, 324, 400 (980 total);
  - QUANTIZE ends at row = 19, col = 19, addr = 399.
- Backpressure: random win_ready at ~50% duty → no position skipped or duplicated. Positions are strictly column-major, and window outputs hold steady while win_ready is low.
- Write-back stall: hold wb_ack low for 10 cycles → wb_req stays high, win_valid stays 0, and op is unchanged until the ack.
- Ignored inputs:
  - start pulses while busy → no restart;
  - toggling mode mid-run → pass order unchanged;
  - wb_ack during SCAN → no effect.
